// File: rtl/i2c_reg_slave_if.sv
// Register-bus bundle between the I2C front end and the SPI master's register port.
// master = side issuing strobes (i2c_reg_slave), slave = register file side.
interface i2c_reg_slave_if;
  logic [3:0] o_address;
  logic [7:0] o_data;
  logic       o_wr;
  logic       o_rd;
  logic [7:0] i_data;

  modport master (output o_address, output o_data, output o_wr, output o_rd, input i_data);
  modport slave  (input o_address, input o_data, input o_wr, input o_rd, output i_data);
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C slave front end: turns I2C transactions addressed to SLAVE_ADDR into
// single-cycle write/read strobes on a 4-bit-address, 8-bit-data register bus.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address byte (bits [7:1] addr, bit 0 R/W)
// ADDR_ACK  | driving ACK for a matched address
// WR_BYTE   | shifting in a data byte (first one loads the pointer)
// WR_ACK    | driving ACK for a received data byte
// RD_BYTE   | shifting out tx register, MSB first
// RD_ACK    | SDA released, sampling host ACK/NACK
// WAIT_STOP | not addressed or NACKed; waiting for STOP or START
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3A
) (
  input  logic i_ck,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_oe,
  i2c_reg_slave_if.master reg_bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] tx;
  logic [3:0] ptr;
  logic       first_byte;
  logic       is_read;
  logic       host_ack;
  logic       rd_d1;
  logic       sda_oe_q;
  logic [3:0] addr_q;
  logic [7:0] data_q;
  logic       wr_q;
  logic       rd_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_byte   = {shift[6:0], sda_s2};

  assign o_sda_oe          = sda_oe_q;
  assign reg_bus.o_address = addr_q;
  assign reg_bus.o_data    = data_q;
  assign reg_bus.o_wr      = wr_q;
  assign reg_bus.o_rd      = rd_q;

  // Synchronizers keep tracking the pins through reset so no phantom edges appear on release.
  always_ff @(posedge i_ck) begin
    scl_s1 <= i_scl;
    scl_s2 <= scl_s1;
    scl_d  <= scl_s2;
    sda_s1 <= i_sda;
    sda_s2 <= sda_s1;
    sda_d  <= sda_s2;
  end

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      tx         <= 8'h00;
      ptr        <= 4'd0;
      first_byte <= 1'b0;
      is_read    <= 1'b0;
      host_ack   <= 1'b0;
      rd_d1      <= 1'b0;
      sda_oe_q   <= 1'b0;
      addr_q     <= 4'd0;
      data_q     <= 8'h00;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      rd_d1 <= rd_q;
      // Read data is valid the cycle after o_rd; the pointer advances once it is captured.
      if (rd_d1) begin
        tx  <= reg_bus.i_data;
        ptr <= ptr + 4'd1;
      end

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= 4'd0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shift[7:1] == SLAVE_ADDR) begin
                state    <= ADDR_ACK;
                sda_oe_q <= 1'b1;
                is_read  <= shift[0];
                if (shift[0]) begin
                  rd_q   <= 1'b1;
                  addr_q <= ptr;
                end
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (is_read) begin
                state    <= RD_BYTE;
                sda_oe_q <= ~tx[7];
              end else begin
                state      <= WR_BYTE;
                sda_oe_q   <= 1'b0;
                first_byte <= 1'b1;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                first_byte <= 1'b0;
                if (first_byte) begin
                  ptr <= rx_byte[3:0];
                end else begin
                  wr_q   <= 1'b1;
                  addr_q <= ptr;
                  data_q <= rx_byte;
                  ptr    <= ptr + 4'd1;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state    <= WR_ACK;
              sda_oe_q <= 1'b1;
              bit_cnt  <= 4'd0;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state    <= WR_BYTE;
              sda_oe_q <= 1'b0;
            end
          end
          RD_BYTE: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                // Prefetch the next byte while the host clocks its ACK.
                state    <= RD_ACK;
                sda_oe_q <= 1'b0;
                rd_q     <= 1'b1;
                addr_q   <= ptr;
                bit_cnt  <= 4'd0;
              end else if (bit_cnt != 4'd0) begin
                sda_oe_q <= ~tx[3'd7 - bit_cnt[2:0]];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              host_ack <= ~sda_s2;
            end else if (scl_fall) begin
              if (host_ack) begin
                state    <= RD_BYTE;
                sda_oe_q <= ~tx[7];
              end else begin
                state    <= WAIT_STOP;
                sda_oe_q <= 1'b0;
              end
            end
          end
          WAIT_STOP: sda_oe_q <= 1'b0;
          default:   state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C host, registered read-data
// model, and queues of expected register strobes checked as they appear.
module tb_i2c_reg_slave;

  localparam int T = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic host_scl = 1'b1;
  logic host_sda = 1'b1;
  logic sda_oe;
  logic sda_line;
  logic oe_seen = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];

  i2c_reg_slave_if bus ();

  assign sda_line = host_sda & ~sda_oe;

  i2c_reg_slave #(.SLAVE_ADDR(7'h3A)) dut (
    .i_ck     (clk),
    .i_rst    (rst),
    .i_scl    (host_scl),
    .i_sda    (sda_line),
    .o_sda_oe (sda_oe),
    .reg_bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_model(input logic [3:0] a);
    case (a)
      4'd3:    return 8'h5A;
      4'd4:    return 8'hC3;
      default: return {4'hE, a};
    endcase
  endfunction

  initial bus.i_data = 8'h00;
  always @(posedge clk) if (bus.o_rd) bus.i_data <= rd_model(bus.o_address);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (bus.o_wr) begin
        check("wr_expected", 16'(exp_wr.size() != 0), 16'd1);
        check("wr_rd_excl", 16'(bus.o_rd), 16'd0);
        if (exp_wr.size() != 0) check("wr_addr_data", {4'h0, bus.o_address, bus.o_data}, {4'h0, exp_wr.pop_front()});
      end
      if (bus.o_rd) begin
        check("rd_expected", 16'(exp_rd.size() != 0), 16'd1);
        if (exp_rd.size() != 0) check("rd_addr", 16'(bus.o_address), 16'(exp_rd.pop_front()));
      end
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    host_sda = 1'b1; wq(T);
    host_scl = 1'b1; wq(T);
    host_sda = 1'b0; wq(T);
    host_scl = 1'b0; wq(T);
  endtask

  task automatic i2c_stop();
    host_sda = 1'b0; wq(T);
    host_scl = 1'b1; wq(T);
    host_sda = 1'b1; wq(T);
  endtask

  task automatic write_bit(input logic b);
    host_sda = b;    wq(T);
    host_scl = 1'b1; wq(2 * T);
    host_scl = 1'b0; wq(T);
  endtask

  task automatic read_bit(output logic b);
    host_sda = 1'b1; wq(T);
    host_scl = 1'b1; wq(T);
    b = sda_line;    wq(T);
    host_scl = 1'b0; wq(T);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack_low);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack_low = ~b;
  endtask

  task automatic read_byte(input logic host_ack_bit, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(host_ack_bit);
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] rd;
    logic [7:0] addr_byte;

    // Reset state
    wq(4);
    check("rst_oe", 16'(sda_oe), 16'd0);
    check("rst_wr", 16'(bus.o_wr), 16'd0);
    check("rst_rd", 16'(bus.o_rd), 16'd0);
    check("rst_ptr", 16'(dut.ptr), 16'd0);
    check("rst_state", 16'(dut.state), 16'd0);
    rst = 1'b0;
    wq(4);

    // Write: pointer 1, then two data bytes
    i2c_start();
    send_byte(8'h74, ack); check("wr_ack_addr", 16'(ack), 16'd1);
    send_byte(8'h01, ack); check("wr_ack_ptr", 16'(ack), 16'd1);
    exp_wr.push_back({4'd1, 8'hA5});
    send_byte(8'hA5, ack); check("wr_ack_d0", 16'(ack), 16'd1);
    exp_wr.push_back({4'd2, 8'h3C});
    send_byte(8'h3C, ack); check("wr_ack_d1", 16'(ack), 16'd1);
    i2c_stop();
    wq(T);
    check("wr_ptr_end", 16'(dut.ptr), 16'd3);
    check("wr_q_drained", 16'(exp_wr.size()), 16'd0);
    check("wr_state_idle", 16'(dut.state), 16'd0);

    // Reset in the middle of the address ACK
    i2c_start();
    addr_byte = 8'h74;
    for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
    check("rst_pre_ack_oe", 16'(sda_oe), 16'd1);
    rst = 1'b1;
    wq(2);
    check("rst_mid_oe", 16'(sda_oe), 16'd0);
    check("rst_mid_addr", 16'(bus.o_address), 16'd0);
    check("rst_mid_data", 16'(bus.o_data), 16'd0);
    check("rst_mid_ptr", 16'(dut.ptr), 16'd0);
    rst = 1'b0;
    read_bit(b);
    check("rst_no_ack", 16'(b), 16'd1);
    i2c_stop();
    wq(T);

    // Read via repeated START, pointer set to 3
    i2c_start();
    send_byte(8'h74, ack); check("rd_ack_waddr", 16'(ack), 16'd1);
    send_byte(8'h03, ack); check("rd_ack_ptr", 16'(ack), 16'd1);
    exp_rd.push_back(4'd3);
    exp_rd.push_back(4'd4);
    exp_rd.push_back(4'd5);
    i2c_start();
    send_byte(8'h75, ack); check("rd_ack_raddr", 16'(ack), 16'd1);
    read_byte(1'b0, rd); check("rd_byte0", 16'(rd), 16'h5A);
    read_byte(1'b1, rd); check("rd_byte1", 16'(rd), 16'hC3);
    i2c_stop();
    wq(T);
    check("rd_state_idle", 16'(dut.state), 16'd0);
    check("rd_q_drained", 16'(exp_rd.size()), 16'd0);
    check("rd_oe_released", 16'(sda_oe), 16'd0);

    // Address mismatch
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h76, ack); check("mm_ack_addr", 16'(ack), 16'd0);
    send_byte(8'h00, ack); check("mm_ack_data", 16'(ack), 16'd0);
    i2c_stop();
    wq(T);
    check("mm_oe_never", 16'(oe_seen), 16'd0);

    // Pointer wrap 15 -> 0
    i2c_start();
    send_byte(8'h74, ack); check("wrap_ack_addr", 16'(ack), 16'd1);
    send_byte(8'h0F, ack); check("wrap_ack_ptr", 16'(ack), 16'd1);
    exp_wr.push_back({4'd15, 8'h11});
    send_byte(8'h11, ack); check("wrap_ack_d0", 16'(ack), 16'd1);
    exp_wr.push_back({4'd0, 8'h22});
    send_byte(8'h22, ack); check("wrap_ack_d1", 16'(ack), 16'd1);
    i2c_stop();
    wq(T);
    check("wrap_ptr_end", 16'(dut.ptr), 16'd1);
    check("wrap_q_drained", 16'(exp_wr.size()), 16'd0);

    // Abort: STOP after 4 bits of a data byte
    i2c_start();
    send_byte(8'h74, ack); check("ab_ack_addr", 16'(ack), 16'd1);
    send_byte(8'h05, ack); check("ab_ack_ptr", 16'(ack), 16'd1);
    addr_byte = 8'h99;
    for (int i = 7; i >= 4; i--) write_bit(addr_byte[i]);
    i2c_stop();
    wq(T);
    check("ab_oe", 16'(sda_oe), 16'd0);
    check("ab_state_idle", 16'(dut.state), 16'd0);
    check("ab_ptr", 16'(dut.ptr), 16'd5);
    check("ab_wr_q", 16'(exp_wr.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
